// File: rtl/serial_add_pkg.sv
// Shared constants and state encoding for the bit-serial adder.
package serial_add_pkg;

    localparam int SA_WIDTH = 8;
    localparam int SA_CNT_W = $clog2(SA_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/serial_add_full_add.sv
// One-bit full adder used as the serial datapath's single adder cell.
module full_add (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);

    assign s_o  = a_i ^ b_i ^ ci_i;
    assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_add.sv
// Bit-serial adder, LSB first, start/busy/done handshake.
// Optional subtract mode (port sub) when SERIAL_ADD_SUB_EN is defined.
module serial_add
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             co
);

    localparam int CW = cnt_w(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, y_q;
    logic             c_q, co_q;
    logic [CW-1:0]    cnt_q;
    logic             sub_in, sub_q;
    logic             accept, last_bit;
    logic             fa_s, fa_co;

`ifdef SERIAL_ADD_SUB_EN
    assign sub_in = sub;
`else
    assign sub_in = 1'b0;
`endif

    // A new op is taken from IDLE or straight out of DONE (back-to-back).
    assign accept   = start && (state_q != RUN);
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    full_add u_fa (
        .a_i  (a_q[0]),
        .b_i  (b_q[0]),
        .ci_i (c_q),
        .s_o  (fa_s),
        .co_o (fa_co)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            y_q   <= '0;
            c_q   <= 1'b0;
            co_q  <= 1'b0;
            sub_q <= 1'b0;
            cnt_q <= '0;
        end else if (accept) begin
            // Subtract is a + ~b + ~ci; the borrow is the inverted carry.
            a_q   <= a;
            b_q   <= sub_in ? ~b : b;
            c_q   <= sub_in ? ~ci : ci;
            sub_q <= sub_in;
            cnt_q <= '0;
        end else if (state_q == RUN) begin
            a_q   <= a_q >> 1;
            b_q   <= b_q >> 1;
            y_q   <= {fa_s, y_q[WIDTH-1:1]};
            c_q   <= fa_co;
            cnt_q <= cnt_q + CW'(1);
            if (last_bit) co_q <= sub_q ? ~fa_co : fa_co;
        end
    end

    assign y  = y_q;
    assign co = co_q;

endmodule

// File: tb/tb_serial_add.sv
// Directed self-checking bench for serial_add (WIDTH=8).
module tb_serial_add;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         ci;
`ifdef SERIAL_ADD_SUB_EN
    logic         sub;
`endif
    logic         busy, done, co;
    logic [W-1:0] y;

    int checks = 0;
    int errors = 0;

    serial_add #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .ci    (ci),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .y     (y),
        .co    (co)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Raise start for one edge (E0); busy must be high right after it.
    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic civ);
        a = av; b = bv; ci = civ; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("no_done_after_start", {31'd0, done}, 32'd0);
    endtask

    // Count edges until done appears; it must show after exactly exp_edges edges.
    task automatic wait_done(input string tag, input int exp_edges);
        int lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        chk(tag, lat, exp_edges);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic civ, input logic [W-1:0] ey, input logic eco);
        start_op(av, bv, civ);
        wait_done({tag, "_lat"}, W);
        chk({tag, "_y"}, {24'd0, y}, {24'd0, ey});
        chk({tag, "_co"}, {31'd0, co}, {31'd0, eco});
    endtask

    initial begin
        int seen;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; ci = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        sub = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_y", {24'd0, y}, 32'd0);
        chk("rst_co", {31'd0, co}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("add_1_1", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);
        @(posedge clk); #1;
        chk("idle_after_done", {31'd0, done}, 32'd0);
        chk("y_held_idle", {24'd0, y}, 32'h02);
        run_op("add_1_1_ci", 8'h01, 8'h01, 1'b1, 8'h03, 1'b0);
        run_op("add_81_01", 8'h81, 8'h01, 1'b0, 8'h82, 1'b0);
        run_op("add_7f_ff", 8'h7F, 8'hFF, 1'b0, 8'h7E, 1'b1);
        run_op("add_ff_00_ci", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);

        // start pulsed mid-RUN with other operands must be ignored
        start_op(8'h01, 8'h01, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        a = 8'hFF; b = 8'hFF; ci = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("ign_lat", W - 4);
        chk("ign_y", {24'd0, y}, 32'h02);
        chk("ign_co", {31'd0, co}, 32'd0);

        // back-to-back: start already high in the DONE cycle
        run_op("b2b_first", 8'h81, 8'h01, 1'b0, 8'h82, 1'b0);
        start_op(8'h7F, 8'hFF, 1'b0);
        wait_done("b2b_lat", W);
        chk("b2b_y", {24'd0, y}, 32'h7E);
        chk("b2b_co", {31'd0, co}, 32'd1);

        // reset partway through a RUN discards the op
        start_op(8'h7F, 8'hFF, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_y", {24'd0, y}, 32'd0);
        chk("mid_rst_co", {31'd0, co}, 32'd0);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        chk("mid_rst_quiet", seen, 0);
        run_op("post_rst", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);

`ifdef SERIAL_ADD_SUB_EN
        sub = 1'b1;
        run_op("sub_1_1", 8'h01, 8'h01, 1'b0, 8'h00, 1'b0);
        run_op("sub_1_1_ci", 8'h01, 8'h01, 1'b1, 8'hFF, 1'b1);
        run_op("sub_7f_ff", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1);
        sub = 1'b0;
        run_op("add_after_sub", 8'h7F, 8'hFF, 1'b0, 8'h7E, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
